// File: rtl/loop_nest_controller_if.sv
// rtl/loop_nest_controller_if.sv - control, bound and index-beat signals of the loop nest controller
interface loop_nest_controller_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             abort_i;
    logic [WIDTH-1:0] bound_m_i;
    logic [WIDTH-1:0] bound_n_i;
    logic [WIDTH-1:0] bound_k_i;
    logic             ready_i;
    logic             valid_o;
    logic [WIDTH-1:0] m_o;
    logic [WIDTH-1:0] n_o;
    logic [WIDTH-1:0] k_o;
    logic             first_k_o;
    logic             last_k_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  start_i, abort_i, bound_m_i, bound_n_i, bound_k_i, ready_i,
        output valid_o, m_o, n_o, k_o, first_k_o, last_k_o, busy_o, done_o
    );

    modport master (
        output start_i, abort_i, bound_m_i, bound_n_i, bound_k_i, ready_i,
        input  valid_o, m_o, n_o, k_o, first_k_o, last_k_o, busy_o, done_o
    );
endinterface

// File: rtl/loop_nest_controller.sv
// rtl/loop_nest_controller.sv - three-level (M,N,K) loop index generator with ready/valid beats
module loop_nest_controller #(
    parameter int WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    loop_nest_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_bm;
    logic [WIDTH-1:0] r_bn;
    logic [WIDTH-1:0] r_bk;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_m_nxt;
    logic [WIDTH-1:0] w_n_nxt;
    logic [WIDTH-1:0] w_k_nxt;
    logic [WIDTH-1:0] w_bm_nxt;
    logic [WIDTH-1:0] w_bn_nxt;
    logic [WIDTH-1:0] w_bk_nxt;

    logic             w_valid;
    logic             w_k_at_bound;
    logic             w_n_at_bound;
    logic             w_m_at_bound;

    assign w_valid      = (r_state == ST_RUN);
    assign w_k_at_bound = (r_k == r_bk);
    assign w_n_at_bound = (r_n == r_bn);
    assign w_m_at_bound = (r_m == r_bm);

    // State, index and latched-bound registers; reset discards any run in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_m     <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_bm    <= '0;
            r_bn    <= '0;
            r_bk    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
            r_n     <= w_n_nxt;
            r_k     <= w_k_nxt;
            r_bm    <= w_bm_nxt;
            r_bn    <= w_bn_nxt;
            r_bk    <= w_bk_nxt;
        end
    end

    // Next state and index stepping; bounds are compared before incrementing so an all-ones bound never overflows
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_n_nxt     = r_n;
        w_k_nxt     = r_k;
        w_bm_nxt    = r_bm;
        w_bn_nxt    = r_bn;
        w_bk_nxt    = r_bk;

        case (r_state)
            ST_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    w_bm_nxt    = bus.bound_m_i;
                    w_bn_nxt    = bus.bound_n_i;
                    w_bk_nxt    = bus.bound_k_i;
                    w_m_nxt     = '0;
                    w_n_nxt     = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort_i) begin
                    w_m_nxt     = '0;
                    w_n_nxt     = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = ST_IDLE;
                end else if (bus.ready_i) begin
                    if (!w_k_at_bound) begin
                        w_k_nxt = r_k + WIDTH'(1);
                    end else begin
                        w_k_nxt = '0;
                        if (!w_n_at_bound) begin
                            w_n_nxt = r_n + WIDTH'(1);
                        end else begin
                            w_n_nxt = '0;
                            if (!w_m_at_bound) begin
                                w_m_nxt = r_m + WIDTH'(1);
                            end else begin
                                // final beat accepted: indices go back to 0 for the idle view
                                w_m_nxt     = '0;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                w_m_nxt     = '0;
                w_n_nxt     = '0;
                w_k_nxt     = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_m_nxt     = '0;
                w_n_nxt     = '0;
                w_k_nxt     = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.valid_o   = w_valid;
    assign bus.m_o       = r_m;
    assign bus.n_o       = r_n;
    assign bus.k_o       = r_k;
    assign bus.first_k_o = w_valid && (r_k == '0);
    assign bus.last_k_o  = w_valid && w_k_at_bound;
    assign bus.busy_o    = (r_state != ST_IDLE);
    assign bus.done_o    = (r_state == ST_DONE);
endmodule

// File: tb/tb_loop_nest_controller.sv
// tb/tb_loop_nest_controller.sv - scoreboard bench for loop_nest_controller
module tb_loop_nest_controller;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    loop_nest_controller_if #(.WIDTH(W)) u_if ();

    loop_nest_controller #(.WIDTH(W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    typedef struct {
        int m;
        int n;
        int k;
        int f;
        int l;
    } beat_t;

    beat_t exp_q[$];
    int    exp_done   = 0;
    int    n_cmp      = 0;
    int    n_err      = 0;
    int    ready_mode = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int pack3(input int m, input int n, input int k);
        return m * 65536 + n * 256 + k;
    endfunction

    function automatic int idx_now();
        return pack3(int'(u_if.m_o), int'(u_if.n_o), int'(u_if.k_o));
    endfunction

    function automatic int all_outs();
        return int'({u_if.valid_o, u_if.busy_o, u_if.done_o, u_if.first_k_o,
                      u_if.last_k_o, u_if.m_o, u_if.n_o, u_if.k_o});
    endfunction

    // Reference model: the nest written as plain loops, M outermost
    function automatic void model(input int bm, input int bn, input int bk, input bit with_done);
        beat_t b;
        for (int m = 0; m <= bm; m++)
            for (int n = 0; n <= bn; n++)
                for (int k = 0; k <= bk; k++) begin
                    b.m = m; b.n = n; b.k = k;
                    b.f = (k == 0) ? 1 : 0;
                    b.l = (k == bk) ? 1 : 0;
                    exp_q.push_back(b);
                end
        if (with_done) exp_done++;
    endfunction

    // Downstream ready: always on or coin-flip per cycle
    always @(posedge clk) begin
        #1;
        u_if.ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: pops expected beats on every transfer, checks stalls, idle outputs and done pulses
    logic p_stall = 1'b0;
    logic p_xfer  = 1'b0;
    int   p_idx   = 0;
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            p_stall = 1'b0;
            p_xfer  = 1'b0;
        end else begin
            if (p_stall) begin
                chk("stall_valid", int'(u_if.valid_o), 1);
                chk("stall_idx", idx_now(), p_idx);
            end
            if (!u_if.busy_o) chk("idle_outputs", all_outs(), 0);
            if (u_if.done_o) begin
                chk("done_after_last_beat", int'(p_xfer), 1);
                chk("done_without_valid", int'(u_if.valid_o), 0);
                n_cmp++;
                if (exp_done == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done_o=1 expected no pulse");
                end else begin
                    exp_done--;
                end
            end
            if (u_if.valid_o && u_if.ready_i && !u_if.abort_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got idx %0d expected none", idx_now());
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_idx", idx_now(), pack3(b.m, b.n, b.k));
                    chk("beat_flags", int'({u_if.first_k_o, u_if.last_k_o}), b.f * 2 + b.l);
                end
            end
            p_xfer  = u_if.valid_o && u_if.ready_i && !u_if.abort_i;
            p_stall = u_if.valid_o && !u_if.ready_i && !u_if.abort_i;
            p_idx   = idx_now();
        end
    end

    task automatic begin_run(input int bm, input int bn, input int bk, input bit with_done);
        u_if.bound_m_i = W'(bm);
        u_if.bound_n_i = W'(bn);
        u_if.bound_k_i = W'(bk);
        u_if.start_i   = 1'b1;
        model(bm, bn, bk, with_done);
        @(posedge clk); #1;
        u_if.start_i = 1'b0;
        chk("first_beat_valid", int'(u_if.valid_o), 1);
        chk("first_beat_busy", int'(u_if.busy_o), 1);
    endtask

    task automatic finish_run();
        int cyc = 0;
        while ((exp_q.size() != 0 || exp_done != 0) && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 5000) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: got %0d beats left expected 0", exp_q.size());
            exp_q.delete();
            exp_done = 0;
        end
        chk("end_busy", int'(u_if.busy_o), 0);
        chk("end_done", int'(u_if.done_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        u_if.start_i   = 1'b0;
        u_if.abort_i   = 1'b0;
        u_if.bound_m_i = '0;
        u_if.bound_n_i = '0;
        u_if.bound_k_i = '0;
        u_if.ready_i   = 1'b1;

        #3;
        chk("reset_outputs", all_outs(), 0);

        // First start on the first edge after reset release, M=1 N=2 K=3
        #10;
        rst = 1'b0;
        begin_run(1, 2, 3, 1);
        finish_run();

        // All bounds zero: a single beat
        begin_run(0, 0, 0, 1);
        finish_run();

        // Random back-pressure
        ready_mode = 1;
        begin_run(0, 1, 1, 1);
        finish_run();
        ready_mode = 0;

        // Abort at beat (0,1,0), then restart
        begin_run(1, 2, 3, 0);
        cyc = 0;
        while (!(u_if.valid_o && u_if.m_o == 0 && u_if.n_o == 1 && u_if.k_o == 0) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_target_reached", int'(cyc < 100), 1);
        u_if.abort_i = 1'b1;
        @(posedge clk); #1;
        u_if.abort_i = 1'b0;
        chk("abort_valid", int'(u_if.valid_o), 0);
        chk("abort_busy", int'(u_if.busy_o), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        begin_run(1, 2, 3, 1);
        finish_run();

        // Start together with abort in IDLE stays idle
        u_if.start_i = 1'b1;
        u_if.abort_i = 1'b1;
        @(posedge clk); #1;
        u_if.start_i = 1'b0;
        u_if.abort_i = 1'b0;
        chk("start_abort_idle", int'(u_if.busy_o), 0);

        // New bounds and a start pulse mid-run are ignored
        begin_run(2, 1, 2, 1);
        repeat (5) @(posedge clk);
        #1;
        u_if.bound_m_i = W'($urandom_range(0, 3));
        u_if.bound_n_i = W'($urandom_range(0, 3));
        u_if.bound_k_i = W'($urandom_range(0, 3));
        u_if.start_i   = 1'b1;
        @(posedge clk); #1;
        u_if.start_i = 1'b0;
        finish_run();

        // Random bounds with random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 4; i++) begin
            begin_run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1);
            finish_run();
        end
        ready_mode = 0;

        // Asynchronous reset mid-run between clock edges
        begin_run(2, 2, 2, 0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle", int'(u_if.busy_o), 0);

        // All-ones inner bound: 256 inner beats per N iteration
        begin_run(0, 1, 255, 1);
        finish_run();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
